// File: rtl/disp_pkg.sv
// Shared definitions for the display-sharing arbiter and related shared-resource blocks.
package disp_pkg;

    localparam int NREQ = 4;
    localparam int NDIG = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [3:0] DP_OFF = 4'b1111;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational four-way round-robin picker: searches upward from ptr+1, wrapping,
// so the previous owner (ptr) is considered last.
module rr_pick4
    import disp_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      winner,
    output logic            any
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        any    = |req;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_share_arb.sv
// Time-shares the hex display multiplexer among four requesters with a fixed
// hold period per grant and round-robin rotation on expiry.
module disp_share_arb
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CW          = $clog2(HOLD_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_data,
    input  logic [NDIG*NREQ-1:0] req_dp,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [3:0]           hex3,
    output logic [3:0]           hex2,
    output logic [3:0]           hex1,
    output logic [3:0]           hex0,
    output logic [NDIG-1:0]      dp_out,
    output logic                 busy
);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    state_t          state, state_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      winner;
    logic            any;

    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic [15:0]     hex_nxt;
    logic [NDIG-1:0] dp_nxt;
    logic            busy_nxt;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // State, pointer, counter and all output registers; reset is synchronous, active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ptr    <= 2'd3;
            cnt    <= '0;
            gnt    <= '0;
            done   <= '0;
            hex3   <= '0;
            hex2   <= '0;
            hex1   <= '0;
            hex0   <= '0;
            dp_out <= DP_OFF;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            gnt    <= gnt_nxt;
            done   <= done_nxt;
            hex3   <= hex_nxt[15:12];
            hex2   <= hex_nxt[11:8];
            hex1   <= hex_nxt[7:4];
            hex0   <= hex_nxt[3:0];
            dp_out <= dp_nxt;
            busy   <= busy_nxt;
        end
    end

    // While holding, ptr is the current owner; a dropped owner request wins over expiry.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        done_nxt  = '0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_nxt = ST_HOLD;
                    ptr_nxt   = winner;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!req[ptr]) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    done_nxt  = onehot4(ptr);
                    ptr_nxt   = winner;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Display values follow whoever owns the display after this edge.
    always_comb begin
        gnt_nxt  = '0;
        hex_nxt  = '0;
        dp_nxt   = DP_OFF;
        busy_nxt = 1'b0;
        if (state_nxt == ST_HOLD) begin
            gnt_nxt  = onehot4(ptr_nxt);
            hex_nxt  = req_data[{ptr_nxt, 4'b0000} +: 16];
            dp_nxt   = req_dp[{ptr_nxt, 2'b00} +: NDIG];
            busy_nxt = 1'b1;
        end
    end

endmodule
